// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, optional zero register,
// per-register pending bits for hazard detection and a sequenced clear engine.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                              CLK,
    input  logic                              nRST,
    input  logic [NWRITE-1:0]                 wen,
    input  logic [NWRITE*$clog2(NREGS)-1:0]   wsel,
    input  logic [NWRITE*DATA_W-1:0]          wdat,
    input  logic [NREAD*$clog2(NREGS)-1:0]    rsel,
    output logic [NREAD*DATA_W-1:0]           rdat,
    output logic [NREAD-1:0]                  rpend,
    input  logic                              claim_en,
    input  logic [$clog2(NREGS)-1:0]          claim_sel,
    input  logic                              flush_req,
    output logic                              busy
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]     regs_q [NREGS];
    logic [DATA_W-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]      pend_q, pend_d;

    logic [AW-1:0]         ws;
    logic [AW-1:0]         rs;
    logic [DATA_W-1:0]     rv;
    logic                  hit;
    logic                  rp;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
        end
    end

    // Next state: in IDLE later write ports override earlier ones; a claim
    // overrides the pend-clear of a write; a flush request overrides both for pend.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        ws      = '0;
        for (int r = 0; r < NREGS; r++) regs_d[r] = regs_q[r];
        case (state_q)
            IDLE: begin
                for (int k = 0; k < NWRITE; k++) begin
                    ws = wsel[k*AW +: AW];
                    if (wen[k] && !(ZERO_REG != 0 && ws == '0)) begin
                        regs_d[ws] = wdat[k*DATA_W +: DATA_W];
                        pend_d[ws] = 1'b0;
                    end
                end
                if (claim_en && !(ZERO_REG != 0 && claim_sel == '0)) begin
                    pend_d[claim_sel] = 1'b1;
                end
                if (flush_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    pend_d  = '0;
                end
            end
            CLEAR: begin
                regs_d[idx_q] = '0;
                idx_d         = idx_q + AW'(1);
                if (idx_q == AW'(NREGS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CLEAR);

    // Read ports: stored value, overridden by the highest matching write port.
    always_comb begin
        rdat = '0;
        rpend = '0;
        rs = '0;
        rv = '0;
        hit = 1'b0;
        rp = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            rs  = rsel[i*AW +: AW];
            rv  = regs_q[rs];
            hit = 1'b0;
            for (int k = 0; k < NWRITE; k++) begin
                if (BYPASS != 0 && wen[k] && wsel[k*AW +: AW] == rs) begin
                    hit = 1'b1;
                    if (state_q == IDLE) rv = wdat[k*DATA_W +: DATA_W];
                end
            end
            rp = pend_q[rs] & ~hit;
            if (ZERO_REG != 0 && rs == '0) begin
                rv = '0;
                rp = 1'b0;
            end
            if (state_q == CLEAR) rp = 1'b0;
            rdat[i*DATA_W +: DATA_W] = rv;
            rpend[i]                 = rp;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a two-write-port bypassing instance plus a
// non-bypassing instance, checked through an expected-value queue.
module tb_regfile_mp;
    localparam int VW = 101;

    logic        CLK;
    logic        nRST;
    logic [1:0]  wen;
    logic [9:0]  wsel;
    logic [63:0] wdat;
    logic [9:0]  rsel;
    logic [63:0] rdat;
    logic [1:0]  rpend;
    logic        claim_en;
    logic [4:0]  claim_sel;
    logic        flush_req;
    logic        busy;

    logic        nb_wen;
    logic [4:0]  nb_wsel;
    logic [31:0] nb_wdat;
    logic [4:0]  nb_rsel;
    logic [31:0] nb_rdat;
    logic        nb_rpend;
    logic        nb_claim_en;
    logic [4:0]  nb_claim_sel;
    logic        nb_flush_req;
    logic        nb_busy;

    logic          chk_v;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] msk_q[$];
    string         name_q[$];
    int            total;
    int            bad;

    regfile_mp #(
        .DATA_W(32), .NREGS(32), .NREAD(2), .NWRITE(2), .BYPASS(1), .ZERO_REG(1)
    ) u_dut (
        .CLK(CLK), .nRST(nRST), .wen(wen), .wsel(wsel), .wdat(wdat),
        .rsel(rsel), .rdat(rdat), .rpend(rpend), .claim_en(claim_en),
        .claim_sel(claim_sel), .flush_req(flush_req), .busy(busy)
    );

    regfile_mp #(
        .DATA_W(32), .NREGS(32), .NREAD(1), .NWRITE(1), .BYPASS(0), .ZERO_REG(1)
    ) u_nb (
        .CLK(CLK), .nRST(nRST), .wen(nb_wen), .wsel(nb_wsel), .wdat(nb_wdat),
        .rsel(nb_rsel), .rdat(nb_rdat), .rpend(nb_rpend), .claim_en(nb_claim_en),
        .claim_sel(nb_claim_sel), .flush_req(nb_flush_req), .busy(nb_busy)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // driver tasks
    task automatic tick();
        @(posedge CLK);
        #1;
        chk_v = 1'b0;
    endtask

    task automatic idle();
        wen = '0; wsel = '0; wdat = '0; rsel = '0;
        claim_en = 1'b0; claim_sel = '0; flush_req = 1'b0;
        nb_wen = 1'b0; nb_wsel = '0; nb_wdat = '0; nb_rsel = '0;
        nb_claim_en = 1'b0; nb_claim_sel = '0; nb_flush_req = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] sel, input logic [31:0] dat);
        wen[port] = 1'b1;
        wsel[port*5 +: 5] = sel;
        wdat[port*32 +: 32] = dat;
    endtask

    task automatic rd(input int port, input logic [4:0] sel);
        rsel[port*5 +: 5] = sel;
    endtask

    task automatic exp_chk(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] pd, input logic bz,
                           input logic use_nb, input logic [31:0] nbd);
        exp_q.push_back({1'b0, 1'b0, nbd, bz, pd, d1, d0});
        msk_q.push_back(use_nb ? {VW{1'b1}} : {34'd0, {67{1'b1}}});
        name_q.push_back(nm);
        chk_v = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (chk_v) begin
            logic [VW-1:0] act, e, m;
            string nm;
            act = {nb_busy, nb_rpend, nb_rdat, busy, rpend, rdat};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: got %h with no expected entry", act);
            end else begin
                e = exp_q.pop_front();
                m = msk_q.pop_front();
                nm = name_q.pop_front();
                if ((act & m) !== (e & m)) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", nm, act & m, e & m);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad = 0;
        chk_v = 1'b0;
        nRST = 1'b0;
        idle();
        tick();
        tick();
        rd(1, 5'd31);
        exp_chk("in_reset", 0, 0, 2'b00, 1'b0, 1'b1, 0);
        tick();
        nRST = 1'b1;

        for (int i = 0; i < 32; i++) begin
            idle();
            rd(0, 5'(i));
            rd(1, 5'(31 - i));
            nb_rsel = 5'(i);
            exp_chk("reset_read", 0, 0, 2'b00, 1'b0, 1'b1, 0);
            tick();
        end

        // same-cycle bypass vs. stored read
        idle();
        wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd5);
        nb_wen = 1'b1; nb_wsel = 5'd5; nb_wdat = 32'hDEADBEEF; nb_rsel = 5'd5;
        exp_chk("bypass_r5", 32'hDEADBEEF, 0, 2'b00, 1'b0, 1'b1, 0);
        tick();
        idle();
        rd(1, 5'd5); nb_rsel = 5'd5;
        exp_chk("stored_r5", 0, 32'hDEADBEEF, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
        tick();

        // two ports hitting the same register; zero register
        idle();
        wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2); rd(0, 5'd7); rd(1, 5'd9);
        exp_chk("dual_wr_bypass", 32'h2, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        wr(0, 5'd0, 32'hFFFFFFFF); rd(0, 5'd7); rd(1, 5'd0);
        exp_chk("zero_wr_same", 32'h2, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        rd(0, 5'd7); rd(1, 5'd0);
        exp_chk("zero_wr_after", 32'h2, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();

        // pending bits
        idle();
        claim_en = 1'b1; claim_sel = 5'd9; rd(0, 5'd9);
        exp_chk("claim_cycle", 0, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        rd(0, 5'd9);
        exp_chk("claim_pend", 0, 0, 2'b01, 1'b0, 1'b0, 0);
        tick();
        idle();
        wr(0, 5'd9, 32'h55); rd(0, 5'd9); rd(1, 5'd9);
        exp_chk("writeback_byp", 32'h55, 32'h55, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        rd(0, 5'd9);
        exp_chk("writeback_done", 32'h55, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        wr(0, 5'd9, 32'h66); claim_en = 1'b1; claim_sel = 5'd9; rd(0, 5'd9);
        exp_chk("claim_and_wr", 32'h66, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        rd(0, 5'd9);
        exp_chk("claim_wins", 32'h66, 0, 2'b01, 1'b0, 1'b0, 0);
        tick();

        // flush sequence
        for (int i = 1; i < 32; i++) begin
            idle();
            wr(0, 5'(i), 32'(i));
            tick();
        end
        idle();
        claim_en = 1'b1; claim_sel = 5'd12;
        tick();
        idle();
        claim_en = 1'b1; claim_sel = 5'd9; rd(0, 5'd12); rd(1, 5'd9);
        exp_chk("preflush", 32'd12, 32'd9, 2'b01, 1'b0, 1'b0, 0);
        tick();
        idle();
        flush_req = 1'b1; wr(0, 5'd3, 32'h77); claim_en = 1'b1; claim_sel = 5'd3;
        rd(0, 5'd12); rd(1, 5'd9);
        exp_chk("flush_req_cyc", 32'd12, 32'd9, 2'b11, 1'b0, 1'b0, 0);
        tick();
        for (int j = 0; j < 32; j++) begin
            idle();
            wr(0, 5'd3, 32'hAA); claim_en = 1'b1; claim_sel = 5'd3;
            rd(0, 5'd3); rd(1, 5'd12);
            exp_chk("clearing", (j <= 3) ? 32'h77 : 32'h0, (j <= 12) ? 32'd12 : 32'h0,
                    2'b00, 1'b1, 1'b0, 0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            idle();
            rd(0, 5'(i)); rd(1, 5'(i));
            exp_chk("post_flush", 0, 0, 2'b00, 1'b0, 1'b0, 0);
            tick();
        end

        // reset in the middle of a flush
        idle();
        wr(0, 5'd20, 32'h20);
        tick();
        idle();
        flush_req = 1'b1; rd(0, 5'd20);
        exp_chk("flush2_req", 32'h20, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        for (int j = 0; j < 10; j++) begin
            idle();
            rd(0, 5'd20);
            exp_chk("flush2_busy", 32'h20, 0, 2'b00, 1'b1, 1'b0, 0);
            tick();
        end
        nRST = 1'b0;
        idle();
        rd(0, 5'd20); rd(1, 5'd5);
        exp_chk("mid_flush_rst", 0, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        nRST = 1'b1;
        idle();
        wr(0, 5'd4, 32'h44); rd(0, 5'd4);
        exp_chk("post_rst_byp", 32'h44, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();
        idle();
        rd(0, 5'd4); rd(1, 5'd20);
        exp_chk("post_rst_read", 32'h44, 0, 2'b00, 1'b0, 1'b0, 0);
        tick();

        idle();
        tick();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next generation of the single-write, dual-read file in the datapath. Adds:
- configurable width, depth and read/write port counts
- optional same-cycle write-to-read bypass
- optional hardwired zero register
- per-register pending (scoreboard) bits for hazard detection
- a sequenced synchronous clear (flush) engine

Sits between the decode and writeback stages of the pipelined core.

Parameters:
DATA_W, 32, data word width in bits
NREGS, 32, number of registers (power of 2, >=2); AW = $clog2(NREGS)
NREAD, 2, number of read ports (>=1)
NWRITE, 1, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never pends

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
wen  input  NWRITE  per-port write enable
wsel  input  NWRITE*AW  per-port write index, port k at [k*AW +: AW]
wdat  input  NWRITE*DATA_W  per-port write data
rsel  input  NREAD*AW  per-port read index
rdat  output  NREAD*DATA_W  per-port read data (combinational)
rpend  output  NREAD  per-port: selected register has a pending producer
claim_en  input  1  mark claim_sel as pending (instruction issued)
claim_sel  input  AW  register being claimed
flush_req  input  1  start synchronous clear sequence (level, sampled in IDLE)
busy  output  1  flush in progress; writes and claims ignored

Behaviour:
- Reset: nRST is asynchronous, active-low; clock CLK.
  - All registers 0, all pend bits 0, FSM = IDLE, busy = 0, flush index = 0.
  - Hence rdat = 0 and rpend = 0 on every port.
- Writes, IDLE only, take effect at posedge:
  - reg[wsel_k] <= wdat_k for every k with wen_k.
  - Same wsel on several enabled ports: highest port index wins.
  - ZERO_REG=1: writes to index 0 dropped.
- Reads, combinational, zero latency:
  - rdat_i = reg[rsel_i].
  - ZERO_REG=1 and rsel_i = 0: always 0; bypass is not applied.
  - BYPASS=1, IDLE, and some enabled write port targets rsel_i: rdat_i = that port's wdat, highest index wins.
  - Bypass is never applied while busy.
- Pending bits, IDLE only:
  - Enabled write to r clears pend[r] at posedge.
  - claim_en sets pend[claim_sel] at posedge.
  - Claim and write to same register in same cycle: claim wins, pend stays 1.
  - ZERO_REG=1: claims of index 0 ignored.
- rpend_i = pend[rsel_i] AND NOT (BYPASS=1 AND an enabled write targets rsel_i this cycle).
  - Forced 0 for index 0 when ZERO_REG=1.
  - Forced 0 while busy.
- Flush FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when flush_req=1 at posedge. On that edge all pend bits clear and index <= 0. That cycle's writes and claims still apply, except that pend bits end 0.
  - In CLEAR:
    - busy = 1.
    - Each cycle reg[index] <= 0 and index increments.
    - After clearing index NREGS-1, return to IDLE; index wraps to 0.
    - Duration is exactly NREGS cycles with busy high.
    - All wen and claim_en are ignored.
    - flush_req is ignored; it is not queued.
  - flush_req still high on the first IDLE cycle after CLEAR starts a new flush.
- nRST asserted mid-flush: immediate return to the reset state; no partial state is retained.
- Write index >= NREGS cannot occur (NREGS is a power of 2).

Test Plan:
- Reset, then read all ports at indices 0..31 -> rdat = 0, rpend = 0, busy = 0.
- Write r5 = 0xDEADBEEF; same cycle read rsel0 = 5 (BYPASS=1) -> rdat0 = 0xDEADBEEF in that cycle. Next cycle rsel1 = 5 -> 0xDEADBEEF. With BYPASS=0, the same-cycle read gives 0.
- NWRITE=2: port0 r7 = 0x1, port1 r7 = 0x2 same cycle -> r7 = 0x2. Write r0 = 0xFFFF_FFFF -> rdat at index 0 stays 0.
- Claim r9 -> rpend for r9 = 1 next cycle. Writeback r9 = 0x55 with read rsel = 9 same cycle -> rpend = 0, rdat = 0x55. Claim r9 plus write r9 same cycle -> pend stays 1.
- Load r1..r31 = index value, pulse flush_req for 1 cycle -> busy high exactly 32 cycles. A write of r3 = 0xAA issued during busy is dropped. Afterwards all registers read 0 and all pend = 0.
- Assert nRST at cycle 10 of a flush -> busy = 0 and all registers 0 immediately. A following write and read operate normally.
